// File: rtl/cam_capture_ctrl.sv
// Purpose : camera-side write controller; packs RGB444 byte pairs from an
//           OV7670-style stream into 12-bit pixels and writes the frame buffer.
// Latency : px_wr asserts on the edge that samples the second byte of a pixel;
//           frame_done pulses one clk after the state machine reaches DONE.
// Backpressure: none; the camera cannot be stalled. Pixels beyond the image
//           area are dropped and flagged on the sticky ovf output.
//
// Ports:
//   clk, rst               pixel clock, asynchronous active-low reset
//   init                   1 = capture frames continuously, 0 = stop after current frame
//   vsync, href, px_data   camera frame sync, line valid, byte
//   mem_px_addr/_data      buffer write address (pixel index) and RGB444 data
//   px_wr                  one-cycle write strobe per pixel
//   frame_done             one-cycle pulse per completed captured frame
//   busy                   high while waiting for or capturing a frame
//   ovf                    frame held more than IMG_W*IMG_H pixels; cleared at next SOF
module cam_capture_ctrl #(
    parameter int AW    = 15,
    parameter int DW    = 12,
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    px_data,
    output logic [AW-1:0] mem_px_addr,
    output logic [DW-1:0] mem_px_data,
    output logic          px_wr,
    output logic          frame_done,
    output logic          busy,
    output logic          ovf
);

    // Address one past the last image pixel; it holds the reserved black
    // pixel and must never be written by the camera side.
    localparam logic [AW-1:0] NPIX = AW'(IMG_W * IMG_H);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SOF,
        S_BYTE1,
        S_BYTE2,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          vsync_q;
    logic [3:0]    red_q;
    logic [3:0]    red_nxt;
    logic          sof;
    logic          eof;

    logic [AW-1:0] addr_nxt;
    logic [DW-1:0] data_nxt;
    logic          wr_nxt;
    logic          done_nxt;
    logic          busy_nxt;
    logic          ovf_nxt;

    // vsync high = blanking, so its falling edge opens a frame and its
    // rising edge closes one.
    assign sof = vsync_q & ~vsync;
    assign eof = ~vsync_q & vsync;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            vsync_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            vsync_q <= vsync;
        end
    end

    // Next-state logic; vsync edges win over href in the capture states.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:     if (init) state_nxt = S_WAIT_SOF;
            S_WAIT_SOF: if (sof)  state_nxt = S_BYTE1;
            S_BYTE1: begin
                if (eof)       state_nxt = S_DONE;
                else if (href) state_nxt = S_BYTE2;
            end
            S_BYTE2: begin
                // href low here means the line ended on an odd byte; that
                // byte is discarded and the next line realigns on BYTE1.
                if (eof) state_nxt = S_DONE;
                else     state_nxt = S_BYTE1;
            end
            S_DONE:     state_nxt = init ? S_WAIT_SOF : S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Output next-values
    always_comb begin
        addr_nxt = mem_px_addr;
        data_nxt = mem_px_data;
        red_nxt  = red_q;
        wr_nxt   = 1'b0;
        ovf_nxt  = ovf;
        done_nxt = (state == S_DONE);
        busy_nxt = (state_nxt == S_WAIT_SOF) || (state_nxt == S_BYTE1) ||
                   (state_nxt == S_BYTE2);

        // The address advances on the cycle after each write, so it equals
        // the pixel index for the whole px_wr cycle. Writes only happen below
        // NPIX, which makes the address saturate at NPIX.
        if (px_wr) addr_nxt = mem_px_addr + 1'b1;

        unique case (state)
            S_WAIT_SOF: begin
                if (sof) begin
                    addr_nxt = '0;
                    ovf_nxt  = 1'b0;
                end
            end
            S_BYTE1: begin
                if (!eof && href) red_nxt = px_data[3:0];
            end
            S_BYTE2: begin
                if (!eof && href) begin
                    if (mem_px_addr < NPIX) begin
                        data_nxt = DW'({red_q, px_data});
                        wr_nxt   = 1'b1;
                    end else begin
                        ovf_nxt  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_px_addr <= '0;
            mem_px_data <= '0;
            red_q       <= '0;
            px_wr       <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            mem_px_addr <= addr_nxt;
            mem_px_data <= data_nxt;
            red_q       <= red_nxt;
            px_wr       <= wr_nxt;
            frame_done  <= done_nxt;
            busy        <= busy_nxt;
            ovf         <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
module tb_cam_capture_ctrl;

    localparam int AW   = 15;
    localparam int DW   = 12;
    localparam int NPIX = 160 * 120;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          init    = 1'b0;
    logic          vsync   = 1'b1;
    logic          href    = 1'b0;
    logic [7:0]    px_data = 8'h00;
    logic [AW-1:0] mem_px_addr;
    logic [DW-1:0] mem_px_data;
    logic          px_wr;
    logic          frame_done;
    logic          busy;
    logic          ovf;

    cam_capture_ctrl #(.AW(AW), .DW(DW), .IMG_W(160), .IMG_H(120)) dut (
        .clk         (clk),
        .rst         (rst),
        .init        (init),
        .vsync       (vsync),
        .href        (href),
        .px_data     (px_data),
        .mem_px_addr (mem_px_addr),
        .mem_px_data (mem_px_data),
        .px_wr       (px_wr),
        .frame_done  (frame_done),
        .busy        (busy),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    int n_chk   = 0;
    int n_fail  = 0;
    int fd_seen = 0;
    int fd_exp  = 0;
    int pix_cnt = 0;

    // Expected writes in order, plus an unpopped log used to pin the model.
    int            exp_addr[$];
    logic [DW-1:0] exp_dat[$];
    int            log_addr[$];
    logic [DW-1:0] log_dat[$];

    logic [7:0]    lbuf[$];
    int            pre_len[$];
    logic [7:0]    pre_byte[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare process: every write must be the next expected pixel.
    logic prev_wr = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            if (px_wr) begin
                check("wr_single_cycle", 32'(prev_wr), 32'd0);
                if (exp_addr.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_wr: got write addr %0d data 0x%0h, expected no write",
                             mem_px_addr, mem_px_data);
                end else begin
                    check("wr_addr", 32'(mem_px_addr), 32'(exp_addr.pop_front()));
                    check("wr_data", 32'(mem_px_data), 32'(exp_dat.pop_front()));
                end
            end
            if (frame_done) fd_seen++;
        end
        prev_wr = px_wr;
    end

    // Model of one captured line: consecutive byte pairs form pixels, a
    // trailing odd byte is lost, and only the first NPIX pixels are stored.
    task automatic model_line();
        for (int k = 0; k + 1 < lbuf.size(); k += 2) begin
            if (pix_cnt < NPIX) begin
                exp_addr.push_back(pix_cnt);
                exp_dat.push_back({lbuf[k][3:0], lbuf[k+1]});
                log_addr.push_back(pix_cnt);
                log_dat.push_back({lbuf[k][3:0], lbuf[k+1]});
            end
            pix_cnt++;
        end
    endtask

    task automatic drive_line();
        for (int i = 0; i < lbuf.size(); i++) begin
            href    = 1'b1;
            px_data = lbuf[i];
            tick();
        end
        href    = 1'b0;
        px_data = 8'($urandom_range(0, 255));
    endtask

    task automatic reset_mid_frame();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_outputs_zero",
                  32'({px_wr, frame_done, busy, ovf, mem_px_addr, mem_px_data}), 32'd0);
        end
        init = 1'b0;
        href = 1'b0;
        rst  = 1'b1;
        tick();
        check("rst_release_busy", 32'(busy), 32'd0);
        check("rst_pending_writes", 32'(exp_addr.size()), 32'd0);
        exp_addr.delete();
        exp_dat.delete();
        vsync = 1'b1;
        tick();
    endtask

    // One camera frame. The DUT must already be waiting for SOF when cap=1.
    task automatic run_frame(input int nlines, input int len, input bit cap, input int gap_max,
                             input int chg_line, input bit chg_val, input int abort_line,
                             input bit preset);
        int pidx = 0;
        int n;
        vsync = 1'b1;
        repeat (2) tick();
        vsync = 1'b0;
        tick();
        if (cap) begin
            pix_cnt = 0;
            check("sof_addr", 32'(mem_px_addr), 32'd0);
            check("sof_ovf", 32'(ovf), 32'd0);
            check("sof_busy", 32'(busy), 32'd1);
        end
        tick();
        for (int l = 0; l < nlines; l++) begin
            if (l == chg_line) init = chg_val;
            if (l == abort_line) begin
                reset_mid_frame();
                return;
            end
            lbuf.delete();
            if (preset) begin
                for (int i = 0; i < pre_len[l]; i++) lbuf.push_back(pre_byte[pidx++]);
            end else begin
                n = (len > 0) ? len : int'($urandom_range(1, 40));
                for (int i = 0; i < n; i++) lbuf.push_back(8'($urandom_range(0, 255)));
            end
            if (cap) model_line();
            drive_line();
            repeat ($urandom_range(1, gap_max)) tick();
        end
        vsync = 1'b1;
        tick();
        check("eof_fd_early", 32'(frame_done), 32'd0);
        tick();
        check("eof_fd_pulse", 32'(frame_done), 32'(cap));
        check("eof_missing_writes", 32'(exp_addr.size()), 32'd0);
        if (cap) begin
            fd_exp++;
            check("eof_addr", 32'(mem_px_addr), 32'((pix_cnt < NPIX) ? pix_cnt : NPIX));
            check("eof_ovf", 32'(ovf), 32'(pix_cnt > NPIX));
        end
        tick();
        check("eof_fd_end", 32'(frame_done), 32'd0);
        check("eof_busy", 32'(busy), 32'(init));
    endtask

    initial begin
        // Reset while random traffic runs.
        #2 rst = 1'b0;
        init = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vsync   = 1'($urandom_range(0, 1));
            href    = 1'($urandom_range(0, 1));
            px_data = 8'($urandom_range(0, 255));
            tick();
            check("rst_outputs_zero",
                  32'({px_wr, frame_done, busy, ovf, mem_px_addr, mem_px_data}), 32'd0);
        end
        init  = 1'b0;
        vsync = 1'b1;
        href  = 1'b0;
        rst   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_busy_wr", 32'({busy, px_wr}), 32'd0);
        end

        // Nominal two-pixel frame.
        init = 1'b1;
        log_addr.delete();
        log_dat.delete();
        pre_len  = '{4};
        pre_byte = '{8'h0A, 8'h5C, 8'h03, 8'hF1};
        run_frame(1, 0, 1'b1, 3, -1, 1'b0, -1, 1'b1);
        check("pin_nom_cnt", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
            check("pin_nom_a0", 32'(log_addr[0]), 32'd0);
            check("pin_nom_d0", 32'(log_dat[0]), 32'h0A5C);
            check("pin_nom_a1", 32'(log_addr[1]), 32'd1);
            check("pin_nom_d1", 32'(log_dat[1]), 32'h03F1);
        end

        // Odd line followed by an even line.
        log_addr.delete();
        log_dat.delete();
        pre_len  = '{3, 2};
        pre_byte = '{8'h01, 8'h23, 8'h04, 8'h45, 8'h67};
        run_frame(2, 0, 1'b1, 3, -1, 1'b0, -1, 1'b1);
        check("pin_odd_cnt", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
            check("pin_odd_d0", 32'(log_dat[0]), 32'h0123);
            check("pin_odd_a1", 32'(log_addr[1]), 32'd1);
            check("pin_odd_d1", 32'(log_dat[1]), 32'h0567);
        end

        // Random short frames.
        for (int f = 0; f < 6; f++)
            run_frame(int'($urandom_range(1, 6)), 0, 1'b1, 3, -1, 1'b0, -1, 1'b0);

        // Reset in the middle of a captured frame: frame abandoned, no frame_done.
        run_frame(4, 0, 1'b1, 3, -1, 1'b0, 2, 1'b0);

        // init rises mid-frame: that frame must not be captured.
        run_frame(4, 0, 1'b0, 3, 1, 1'b1, -1, 1'b0);

        // init drops mid-frame: frame completes, then back to IDLE.
        run_frame(4, 0, 1'b1, 3, 2, 1'b0, -1, 1'b0);

        // Exactly full frame, then a frame one line too long.
        init = 1'b1;
        tick();
        run_frame(120, 320, 1'b1, 1, -1, 1'b0, -1, 1'b0);
        run_frame(121, 320, 1'b1, 1, -1, 1'b0, -1, 1'b0);

        // ovf must clear at the next SOF.
        run_frame(3, 0, 1'b1, 3, -1, 1'b0, -1, 1'b0);

        check("frame_done_count", 32'(fd_seen), 32'(fd_exp));
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
